// File: rtl/id_stage_pipe.sv
// Decode stage: turns one 16-bit instruction per cycle into register-file reads and an
// ID/EX pipeline register, with valid/ready on both sides, load-use bubbles and flush.
module id_stage_pipe #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int SP_REG = 15,
    parameter int DS_REG = 14,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic              flush,
    output logic [REG_AW-1:0] p0_addr,
    output logic [REG_AW-1:0] p1_addr,
    output logic              re0,
    output logic              re1,
    input  logic [DATA_W-1:0] p0,
    input  logic [DATA_W-1:0] p1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_op,
    output logic [DATA_W-1:0] alu1,
    output logic [DATA_W-1:0] alu2,
    output logic [DATA_W-1:0] store_data,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              illegal,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_NAND = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_INC  = 4'h4;
    localparam logic [3:0] OP_SRA  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SLL  = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_LHB  = 4'hA;
    localparam logic [3:0] OP_LLB  = 4'hB;
    localparam logic [3:0] OP_B    = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;

    localparam logic [REG_AW-1:0] SP_ADDR = REG_AW'(SP_REG);
    localparam logic [REG_AW-1:0] DS_ADDR = REG_AW'(DS_REG);

    logic [3:0]        op;
    logic [REG_AW-1:0] f_rd, f_rs, f_rt;
    logic [DATA_W-1:0] imm4_sx, imm4_zx, imm8_sx, imm8_zx;

    logic              d_re0, d_re1, d_we, d_mrd, d_mwr, d_ill;
    logic [REG_AW-1:0] d_a0, d_a1, d_wa;
    logic [DATA_W-1:0] d_alu1, d_alu2, d_sd;

    logic hazard, adv, accept, load;

    assign op      = instr[15:12];
    assign f_rd    = REG_AW'(instr[11:8]);
    assign f_rs    = REG_AW'(instr[7:4]);
    assign f_rt    = REG_AW'(instr[3:0]);
    assign imm4_sx = {{(DATA_W-4){instr[3]}}, instr[3:0]};
    assign imm4_zx = {{(DATA_W-4){1'b0}}, instr[3:0]};
    assign imm8_sx = {{(DATA_W-8){instr[7]}}, instr[7:0]};
    assign imm8_zx = {{(DATA_W-8){1'b0}}, instr[7:0]};

    // Unused read ports, operands and controls stay at zero so nothing downstream sees stale data.
    always_comb begin
        d_re0  = 1'b0;
        d_re1  = 1'b0;
        d_a0   = '0;
        d_a1   = '0;
        d_alu1 = '0;
        d_alu2 = '0;
        d_sd   = '0;
        d_we   = 1'b0;
        d_wa   = '0;
        d_mrd  = 1'b0;
        d_mwr  = 1'b0;
        d_ill  = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_NAND, OP_XOR: begin
                d_re0  = 1'b1;
                d_a0   = f_rs;
                d_re1  = 1'b1;
                d_a1   = f_rt;
                d_alu1 = p0;
                d_alu2 = p1;
                d_we   = 1'b1;
                d_wa   = f_rd;
            end
            OP_INC, OP_SRA, OP_SRL, OP_SLL: begin
                d_re0  = 1'b1;
                d_a0   = f_rs;
                d_alu1 = p0;
                d_alu2 = (op == OP_INC) ? imm4_sx : imm4_zx;
                d_we   = 1'b1;
                d_wa   = f_rd;
            end
            OP_LW: begin
                d_re1  = 1'b1;
                d_a1   = DS_ADDR;
                d_alu1 = p1;
                d_mrd  = 1'b1;
                d_we   = 1'b1;
                d_wa   = f_rd;
            end
            OP_SW: begin
                d_re0  = 1'b1;
                d_a0   = f_rd;
                d_re1  = 1'b1;
                d_a1   = DS_ADDR;
                d_alu1 = p1;
                d_sd   = p0;
                d_mwr  = 1'b1;
            end
            OP_LHB, OP_LLB: begin
                d_re0  = 1'b1;
                d_a0   = f_rd;
                d_alu1 = p0;
                d_alu2 = imm8_zx;
                d_we   = 1'b1;
                d_wa   = f_rd;
            end
            OP_B: begin
                d_alu2 = imm8_sx;
            end
            OP_CALL, OP_RET: begin
                d_re0  = 1'b1;
                d_a0   = SP_ADDR;
                d_alu1 = p0;
                d_alu2 = (op == OP_CALL) ? '1 : DATA_W'(1);
                d_we   = 1'b1;
                d_wa   = SP_ADDR;
            end
            default: d_ill = 1'b1;
        endcase
    end

    assign p0_addr = d_a0;
    assign p1_addr = d_a1;
    assign re0     = d_re0;
    assign re1     = d_re1;

    assign hazard   = out_valid & mem_rd & in_valid &
                      ((d_re0 & (d_a0 == wr_addr)) | (d_re1 & (d_a1 == wr_addr)));
    assign adv      = !out_valid | out_ready;
    assign in_ready = (adv & !hazard) | flush;
    assign accept   = in_valid & in_ready;
    assign load     = accept & !flush & !d_ill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_op     <= '0;
            alu1       <= '0;
            alu2       <= '0;
            store_data <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            illegal    <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            illegal <= accept & !flush & d_ill;
            if (flush || (adv && !load)) begin
                out_valid  <= 1'b0;
                out_op     <= '0;
                alu1       <= '0;
                alu2       <= '0;
                store_data <= '0;
                wr_en      <= 1'b0;
                wr_addr    <= '0;
                mem_rd     <= 1'b0;
                mem_wr     <= 1'b0;
            end else if (load) begin
                out_valid  <= 1'b1;
                out_op     <= op;
                alu1       <= d_alu1;
                alu2       <= d_alu2;
                store_data <= d_sd;
                wr_en      <= d_we;
                wr_addr    <= d_wa;
                mem_rd     <= d_mrd;
                mem_wr     <= d_mwr;
            end
            if (hazard && !flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed vector table, hand-written multi-cycle sequences,
// then randomized traffic against a transaction-level reference model.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, flush;
    logic [15:0] instr;
    logic [3:0]  p0_addr, p1_addr;
    logic        re0, re1;
    logic [15:0] p0, p1;
    logic        out_valid, out_ready;
    logic [3:0]  out_op;
    logic [15:0] alu1, alu2, store_data;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic        mem_rd, mem_wr, illegal;
    logic [15:0] stall_cnt;

    logic [15:0] rf [16];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign p0 = rf[p0_addr];
    assign p1 = rf[p1_addr];

    id_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .flush(flush), .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
        .p0(p0), .p1(p1), .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .alu1(alu1), .alu2(alu2), .store_data(store_data), .wr_en(wr_en), .wr_addr(wr_addr),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .illegal(illegal), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, want, $time);
        end
    endtask

    typedef struct packed {
        logic        re0, re1;
        logic [3:0]  a0, a1;
        logic [3:0]  op;
        logic [15:0] alu1, alu2, sd;
        logic        we;
        logic [3:0]  wa;
        logic        mrd, mwr, ill;
    } dec_t;

    // Reference decode straight from the instruction-set description.
    function automatic dec_t decode(input logic [15:0] ins);
        dec_t d;
        logic [3:0] rd, rs, rt;
        d = '0;
        rd = ins[11:8];
        rs = ins[7:4];
        rt = ins[3:0];
        d.op = ins[15:12];
        case (ins[15:12])
            4'd0, 4'd1, 4'd2, 4'd3: begin
                d.re0 = 1; d.a0 = rs; d.re1 = 1; d.a1 = rt;
                d.alu1 = rf[rs]; d.alu2 = rf[rt]; d.we = 1; d.wa = rd;
            end
            4'd4: begin
                d.re0 = 1; d.a0 = rs; d.alu1 = rf[rs];
                d.alu2 = ins[3] ? (16'hFFF0 | {12'd0, ins[3:0]}) : {12'd0, ins[3:0]};
                d.we = 1; d.wa = rd;
            end
            4'd5, 4'd6, 4'd7: begin
                d.re0 = 1; d.a0 = rs; d.alu1 = rf[rs]; d.alu2 = {12'd0, ins[3:0]};
                d.we = 1; d.wa = rd;
            end
            4'd8: begin
                d.re1 = 1; d.a1 = 4'd14; d.alu1 = rf[14]; d.mrd = 1; d.we = 1; d.wa = rd;
            end
            4'd9: begin
                d.re0 = 1; d.a0 = rd; d.re1 = 1; d.a1 = 4'd14;
                d.alu1 = rf[14]; d.sd = rf[rd]; d.mwr = 1;
            end
            4'd10, 4'd11: begin
                d.re0 = 1; d.a0 = rd; d.alu1 = rf[rd]; d.alu2 = {8'd0, ins[7:0]};
                d.we = 1; d.wa = rd;
            end
            4'd12: d.alu2 = ins[7] ? (16'hFF00 | {8'd0, ins[7:0]}) : {8'd0, ins[7:0]};
            4'd13, 4'd14: begin
                d.re0 = 1; d.a0 = 4'd15; d.alu1 = rf[15];
                d.alu2 = (ins[15:12] == 4'd13) ? 16'hFFFF : 16'h0001;
                d.we = 1; d.wa = 4'd15;
            end
            default: d.ill = 1;
        endcase
        return d;
    endfunction

    typedef struct {
        logic [15:0] instr;
        logic        vld;
        logic [3:0]  op;
        logic [15:0] a1, a2, sd;
        logic        we;
        logic [3:0]  wa;
        logic        mrd, mwr, ill;
    } vec_t;

    vec_t tbl [12];

    dec_t e, m;
    logic mv, mill, hz, adv, irdy, ld;
    logic [15:0] mstall;

    initial begin
        rst = 1'b1; in_valid = 0; flush = 0; out_ready = 1; instr = 16'h0000;
        for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i);
        rf[1] = 16'd5; rf[2] = 16'd7; rf[5] = 16'd10;

        tbl[0]  = '{16'h0312, 1, 4'h0, 16'd5,    16'd7,    16'd0, 1, 4'd3,  0, 0, 0};
        tbl[1]  = '{16'h465E, 1, 4'h4, 16'd10,   16'hFFFE, 16'd0, 1, 4'd6,  0, 0, 0};
        tbl[2]  = '{16'h675E, 1, 4'h6, 16'd10,   16'h000E, 16'd0, 1, 4'd7,  0, 0, 0};
        tbl[3]  = '{16'hC080, 1, 4'hC, 16'd0,    16'hFF80, 16'd0, 0, 4'd0,  0, 0, 0};
        tbl[4]  = '{16'h8400, 1, 4'h8, 16'h100E, 16'd0,    16'd0, 1, 4'd4,  1, 0, 0};
        tbl[5]  = '{16'h9200, 1, 4'h9, 16'h100E, 16'd0,    16'd7, 0, 4'd0,  0, 1, 0};
        tbl[6]  = '{16'hA3AB, 1, 4'hA, 16'h1003, 16'h00AB, 16'd0, 1, 4'd3,  0, 0, 0};
        tbl[7]  = '{16'hD000, 1, 4'hD, 16'h100F, 16'hFFFF, 16'd0, 1, 4'd15, 0, 0, 0};
        tbl[8]  = '{16'hE000, 1, 4'hE, 16'h100F, 16'h0001, 16'd0, 1, 4'd15, 0, 0, 0};
        tbl[9]  = '{16'h5123, 1, 4'h5, 16'd7,    16'd3,    16'd0, 1, 4'd1,  0, 0, 0};
        tbl[10] = '{16'h3A12, 1, 4'h3, 16'd5,    16'd7,    16'd0, 1, 4'd10, 0, 0, 0};
        tbl[11] = '{16'hF123, 0, 4'h0, 16'd0,    16'd0,    16'd0, 0, 4'd0,  0, 0, 1};

        #12;
        chk("rst out_valid", 32'(out_valid), 0);
        chk("rst illegal", 32'(illegal), 0);
        chk("rst stall_cnt", 32'(stall_cnt), 0);
        chk("rst alu1", 32'(alu1), 0);
        chk("rst wr_en", 32'(wr_en), 0);
        @(negedge clk); rst = 1'b0;

        // Load-use: LW r4 then ADD r3 = r4 + r1.
        @(negedge clk); in_valid = 1; instr = 16'h8400;
        @(posedge clk); #1;
        chk("lu lw valid", 32'(out_valid), 1);
        chk("lu lw mem_rd", 32'(mem_rd), 1);
        @(negedge clk); instr = 16'h0341; #1;
        chk("lu hazard in_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        chk("lu bubble", 32'(out_valid), 0);
        chk("lu stall_cnt", 32'(stall_cnt), 1);
        @(negedge clk); #1;
        chk("lu retry in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        chk("lu add valid", 32'(out_valid), 1);
        chk("lu add alu1", 32'(alu1), 32'h1004);
        chk("lu add alu2", 32'(alu2), 5);
        chk("lu add wr_addr", 32'(wr_addr), 3);
        chk("lu stall hold", 32'(stall_cnt), 1);
        @(negedge clk); in_valid = 0;
        @(posedge clk);

        foreach (tbl[i]) begin
            @(negedge clk); in_valid = 1; instr = tbl[i].instr;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].vld));
            chk($sformatf("tbl%0d illegal", i), 32'(illegal), 32'(tbl[i].ill));
            if (tbl[i].vld) begin
                chk($sformatf("tbl%0d out_op", i), 32'(out_op), 32'(tbl[i].op));
                chk($sformatf("tbl%0d alu1", i), 32'(alu1), 32'(tbl[i].a1));
                chk($sformatf("tbl%0d alu2", i), 32'(alu2), 32'(tbl[i].a2));
                chk($sformatf("tbl%0d store_data", i), 32'(store_data), 32'(tbl[i].sd));
                chk($sformatf("tbl%0d wr_en", i), 32'(wr_en), 32'(tbl[i].we));
                chk($sformatf("tbl%0d wr_addr", i), 32'(wr_addr), 32'(tbl[i].wa));
                chk($sformatf("tbl%0d mem_rd", i), 32'(mem_rd), 32'(tbl[i].mrd));
                chk($sformatf("tbl%0d mem_wr", i), 32'(mem_wr), 32'(tbl[i].mwr));
            end
            @(negedge clk); in_valid = 0;
            @(posedge clk); #1;
            chk($sformatf("tbl%0d illegal clear", i), 32'(illegal), 0);
        end

        // Back-pressure: hold ADD for three cycles while XOR waits.
        @(negedge clk); in_valid = 1; instr = 16'h0312; out_ready = 1;
        @(posedge clk); #1;
        chk("bp first valid", 32'(out_valid), 1);
        @(negedge clk); instr = 16'h3A12; out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp in_ready low", 32'(in_ready), 0);
            @(posedge clk); #1;
            chk("bp hold valid", 32'(out_valid), 1);
            chk("bp hold alu1", 32'(alu1), 5);
            chk("bp hold wr_addr", 32'(wr_addr), 3);
            @(negedge clk);
        end
        out_ready = 1; #1;
        chk("bp release in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        chk("bp next valid", 32'(out_valid), 1);
        chk("bp next wr_addr", 32'(wr_addr), 10);

        // Flush with a stalled live entry and an incoming instruction.
        @(negedge clk); out_ready = 0; flush = 1; in_valid = 1; instr = 16'h0312; #1;
        chk("fl in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        chk("fl out_valid", 32'(out_valid), 0);
        chk("fl no illegal", 32'(illegal), 0);
        @(negedge clk); flush = 0; in_valid = 0; out_ready = 1;
        @(posedge clk); #1;
        chk("fl dropped", 32'(out_valid), 0);

        // Reset asserted while a load-use stall is being held.
        @(negedge clk); in_valid = 1; instr = 16'h8400;
        @(posedge clk);
        @(negedge clk); instr = 16'h0341; out_ready = 0;
        @(posedge clk); #1;
        chk("rs stall_cnt", 32'(stall_cnt), 2);
        chk("rs held valid", 32'(out_valid), 1);
        #2 rst = 1'b1; #1;
        chk("rs async valid", 32'(out_valid), 0);
        chk("rs async mem_rd", 32'(mem_rd), 0);
        chk("rs async alu1", 32'(alu1), 0);
        chk("rs async wr_addr", 32'(wr_addr), 0);
        chk("rs async stall_cnt", 32'(stall_cnt), 0);
        @(negedge clk); rst = 1'b0; in_valid = 0; out_ready = 1;

        // Randomized traffic against the reference model.
        for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
        mv = 0; mill = 0; mstall = 0; m = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            instr     = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                         4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            #1;
            e    = decode(instr);
            hz   = mv && m.mrd && in_valid &&
                   ((e.re0 && e.a0 == m.wa) || (e.re1 && e.a1 == m.wa));
            adv  = !mv || out_ready;
            irdy = (adv && !hz) || flush;
            chk("rnd in_ready", 32'(in_ready), 32'(irdy));
            chk("rnd re0", 32'(re0), 32'(e.re0));
            chk("rnd re1", 32'(re1), 32'(e.re1));
            chk("rnd p0_addr", 32'(p0_addr), 32'(e.a0));
            chk("rnd p1_addr", 32'(p1_addr), 32'(e.a1));
            ld = in_valid && irdy && !flush && !e.ill;
            @(posedge clk); #1;
            mill = in_valid && irdy && !flush && e.ill;
            if (hz && !flush && mstall != 16'hFFFF) mstall = mstall + 1;
            if (flush || (adv && !ld)) mv = 0;
            else if (ld) begin mv = 1; m = e; end
            chk("rnd out_valid", 32'(out_valid), 32'(mv));
            chk("rnd illegal", 32'(illegal), 32'(mill));
            chk("rnd stall_cnt", 32'(stall_cnt), 32'(mstall));
            if (mv) begin
                chk("rnd out_op", 32'(out_op), 32'(m.op));
                chk("rnd alu1", 32'(alu1), 32'(m.alu1));
                chk("rnd alu2", 32'(alu2), 32'(m.alu2));
                chk("rnd store_data", 32'(store_data), 32'(m.sd));
                chk("rnd wr_en", 32'(wr_en), 32'(m.we));
                chk("rnd wr_addr", 32'(wr_addr), 32'(m.wa));
                chk("rnd mem_rd", 32'(mem_rd), 32'(m.mrd));
                chk("rnd mem_wr", 32'(mem_wr), 32'(m.mwr));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
